regfile_write_arbiter: RTL

//  Shares the single register-file write port among NUM_REQ requesters (ALU writeback,

---
 rtl/regfile_write_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter sharing the regfile write port; ARB_FIXED_PRIORITY_EN selects fixed priority
module regfile_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic                      drop
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   win;
  logic               found;
  logic               accept;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  logic [NUM_REQ-1:0] grant_nxt;
  logic               we_nxt;
  logic               drop_nxt;
  logic [ADDR_W-1:0]  waddr_nxt;
  logic [DATA_W-1:0]  wdata_nxt;

  // Winner search: first requesting line starting at ptr, wrapping mod NUM_REQ
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = idx[PTR_W-1:0];
      end
    end
  end

  assign accept   = !hold && found;
  assign sel_addr = req_addr[win*ADDR_W +: ADDR_W];
  assign sel_data = req_data[win*DATA_W +: DATA_W];

`ifdef ARB_FIXED_PRIORITY_EN
  // Fixed priority: search always starts at line 0
  assign ptr = '0;
`else
  // Round-robin pointer: moves just past the winner on every accept, frozen otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: WRITE whenever this edge accepts a request
  always_comb begin
    state_nxt = accept ? WRITE : IDLE;
  end

  // Output decode for the next cycle; address/data hold when nothing is accepted
  always_comb begin
    grant_nxt = '0;
    we_nxt    = 1'b0;
    drop_nxt  = 1'b0;
    waddr_nxt = rf_waddr;
    wdata_nxt = rf_wdata;
    if (accept) begin
      grant_nxt = NUM_REQ'(1) << win;
      we_nxt    = (sel_addr != '0);
      drop_nxt  = (sel_addr == '0);
      waddr_nxt = sel_addr;
      wdata_nxt = sel_data;
    end
  end

  // Registered outputs so rf_we comes straight from a flop and cannot glitch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant    <= '0;
      rf_we    <= 1'b0;
      drop     <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      grant    <= grant_nxt;
      rf_we    <= we_nxt;
      drop     <= drop_nxt;
      rf_waddr <= waddr_nxt;
      rf_wdata <= wdata_nxt;
    end
  end

endmodule
